// File: rtl/msg_serializer.sv
// msg_serializer
//   Accepts a whole message (up to MAX_MSG_BYTES bytes) in one handshake and
//   emits it as an AXI-Stream packet of DATA_BYTES-wide beats.
//
//   Parameters
//     MAX_MSG_BYTES  largest message in bytes (multiple of DATA_BYTES)
//     DATA_BYTES     AXI-ST beat width in bytes
//     TKEEP_WIDTH    width of m_tkeep (equal to DATA_BYTES)
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-low reset
//     msg_valid/ready   message handshake
//     msg_length        message length in bytes
//     msg_data          message bytes, byte 0 on [7:0]
//     msg_error         message flagged bad, forwarded on m_tuser with m_tlast
//     m_t*              AXI-ST master (tvalid/tready/tdata/tkeep/tlast/tuser)
//     drop_pulse        one-cycle pulse when a zero-length message is discarded
//
//   Lengths above MAX_MSG_BYTES are truncated to MAX_MSG_BYTES and flagged as
//   errors on m_tuser.
module msg_serializer #(
    parameter int unsigned MAX_MSG_BYTES = 32,
    parameter int unsigned DATA_BYTES    = 8,
    parameter int unsigned TKEEP_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    input  logic [15:0]                msg_length,
    input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
    input  logic                       msg_error,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [8*DATA_BYTES-1:0]    m_tdata,
    output logic [TKEEP_WIDTH-1:0]     m_tkeep,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic                       drop_pulse
);

    localparam int unsigned NumBeats = MAX_MSG_BYTES / DATA_BYTES;
    localparam int unsigned CntW     = $clog2(NumBeats) + 1;
    localparam int unsigned DataW    = 8 * DATA_BYTES;
    localparam int unsigned LenW     = $clog2(MAX_MSG_BYTES + 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                        state_q, state_d;
    logic [CntW-1:0]               beat_q, beat_d;
    logic [CntW-1:0]               last_q, last_d;   // index of final beat
    logic [LenW-1:0]               rem_q, rem_d;     // Le mod DATA_BYTES
    logic                          eflag_q, eflag_d;
    logic                          drop_q, drop_d;
    logic [NumBeats-1:0][DataW-1:0] data_q, data_d;

    logic [15:0] len_clip;
    logic [15:0] nbeats;
    logic        too_long;
    logic        accept;

    logic                  is_last;
    logic [DataW-1:0]      beat_raw;
    logic [DATA_BYTES-1:0] keep;

    assign msg_ready  = rst && (state_q == StIdle);
    assign accept     = msg_valid && msg_ready;
    assign drop_pulse = drop_q;

    always_comb begin
        too_long = msg_length > 16'(MAX_MSG_BYTES);
        len_clip = too_long ? 16'(MAX_MSG_BYTES) : msg_length;
        nbeats   = (len_clip + 16'(DATA_BYTES - 1)) / 16'(DATA_BYTES);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        rem_d   = rem_q;
        eflag_d = eflag_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = msg_data;
                    eflag_d = msg_error || too_long;
                    beat_d  = '0;
                    // Wraps for a zero-length message, but it is never used then.
                    last_d  = CntW'(nbeats - 16'd1);
                    rem_d   = LenW'(len_clip % 16'(DATA_BYTES));
                    if (msg_length == 16'd0) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (m_tready) begin
                    if (beat_q == last_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            last_q  <= '0;
            rem_q   <= '0;
            eflag_q <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            eflag_q <= eflag_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
        end
    end

    // Outputs are pure functions of registered state, so they hold steady
    // while a beat is stalled and clear immediately on reset.
    always_comb begin
        m_tvalid = (state_q == StSend);
        is_last  = m_tvalid && (beat_q == last_q);

        beat_raw = '0;
        for (int i = 0; i < int'(NumBeats); i++) begin
            if (beat_q == CntW'(i)) begin
                beat_raw = data_q[i];
            end
        end

        keep = '0;
        for (int j = 0; j < int'(DATA_BYTES); j++) begin
            if (!m_tvalid) begin
                keep[j] = 1'b0;
            end else if (!is_last || rem_q == '0) begin
                keep[j] = 1'b1;
            end else begin
                keep[j] = LenW'(j) < rem_q;
            end
        end

        m_tdata = '0;
        for (int j = 0; j < int'(DATA_BYTES); j++) begin
            m_tdata[8*j +: 8] = keep[j] ? beat_raw[8*j +: 8] : 8'h00;
        end

        m_tkeep = TKEEP_WIDTH'(keep);
        m_tlast = is_last;
        m_tuser = is_last && eflag_q;
    end

endmodule

// File: tb/tb_msg_serializer.sv
module tb_msg_serializer;

    localparam int MaxB = 32;
    localparam int DB   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              msg_valid;
    logic              msg_ready;
    logic [15:0]       msg_length;
    logic [8*MaxB-1:0] msg_data;
    logic              msg_error;
    logic              m_tvalid;
    logic              m_tready;
    logic [8*DB-1:0]   m_tdata;
    logic [DB-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tuser;
    logic              drop_pulse;

    int checks   = 0;
    int failures = 0;

    logic [8*MaxB-1:0] pattern;
    logic [63:0]       exp_data;

    always #5 clk = ~clk;

    msg_serializer #(
        .MAX_MSG_BYTES(MaxB),
        .DATA_BYTES   (DB),
        .TKEEP_WIDTH  (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_length(msg_length),
        .msg_data  (msg_data),
        .msg_error (msg_error),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .drop_pulse(drop_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] data, input logic [7:0] keep,
                               input logic last, input logic user);
        chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(1'b1));
        chk({tag, "_tdata"},  m_tdata,       data);
        chk({tag, "_tkeep"},  64'(m_tkeep),  64'(keep));
        chk({tag, "_tlast"},  64'(m_tlast),  64'(last));
        chk({tag, "_tuser"},  64'(m_tuser),  64'(user));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one message for a single cycle; returns at the negedge after acceptance.
    task automatic offer(input logic [15:0] len, input logic err);
        msg_valid  = 1'b1;
        msg_length = len;
        msg_error  = err;
        msg_data   = pattern;
        step();
        msg_valid  = 1'b0;
        msg_error  = 1'b0;
        msg_length = 16'd0;
    endtask

    initial begin
        for (int i = 0; i < MaxB; i++) pattern[8*i +: 8] = 8'(i + 1);
        rst        = 1'b0;
        msg_valid  = 1'b0;
        msg_length = 16'd0;
        msg_data   = '0;
        msg_error  = 1'b0;
        m_tready   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_msg_ready", 64'(msg_ready), 64'(1'b0));
        chk("rst_tvalid",    64'(m_tvalid),  64'(1'b0));
        chk("rst_tdata",     m_tdata,        64'h0);
        chk("rst_tkeep",     64'(m_tkeep),   64'h0);
        chk("rst_tlast",     64'(m_tlast),   64'(1'b0));
        chk("rst_tuser",     64'(m_tuser),   64'(1'b0));
        chk("rst_drop",      64'(drop_pulse), 64'(1'b0));
        rst = 1'b1;
        step();
        chk("post_rst_ready", 64'(msg_ready), 64'(1'b1));

        // Length 20, tready held high
        m_tready = 1'b1;
        offer(16'd20, 1'b0);
        expect_beat("t1_b0", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
        chk("t1_ready_in_send", 64'(msg_ready), 64'(1'b0));
        step();
        expect_beat("t1_b1", 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 1'b0);
        step();
        expect_beat("t1_b2", 64'h0000000014131211, 8'h0F, 1'b1, 1'b0);
        step();
        chk("t1_bubble_tvalid", 64'(m_tvalid),  64'(1'b0));
        chk("t1_bubble_ready",  64'(msg_ready), 64'(1'b1));

        // Length 32, tready alternating 0/1
        m_tready = 1'b0;
        offer(16'd32, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) exp_data[8*b +: 8] = 8'(8*k + b + 1);
            expect_beat($sformatf("t2_b%0d", k), exp_data, 8'hFF, k == 3, 1'b0);
            step();
            expect_beat($sformatf("t2_b%0d_stall", k), exp_data, 8'hFF, k == 3, 1'b0);
            m_tready = 1'b1;
            step();
            m_tready = 1'b0;
        end
        chk("t2_end_tvalid", 64'(m_tvalid), 64'(1'b0));

        // Length 8 with error flag
        m_tready = 1'b1;
        offer(16'd8, 1'b1);
        expect_beat("t3_b0", 64'h0807060504030201, 8'hFF, 1'b1, 1'b1);
        step();
        chk("t3_end_tvalid", 64'(m_tvalid), 64'(1'b0));

        // Zero-length message is dropped
        offer(16'd0, 1'b0);
        chk("t4_drop",   64'(drop_pulse), 64'(1'b1));
        chk("t4_tvalid", 64'(m_tvalid),   64'(1'b0));
        chk("t4_ready",  64'(msg_ready),  64'(1'b1));
        step();
        chk("t4_drop_once", 64'(drop_pulse), 64'(1'b0));
        chk("t4_tvalid2",   64'(m_tvalid),   64'(1'b0));

        // Oversize length 40: truncated to 32 bytes, flagged on tlast
        offer(16'd40, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) exp_data[8*b +: 8] = 8'(8*k + b + 1);
            expect_beat($sformatf("t5_b%0d", k), exp_data, 8'hFF, k == 3, k == 3);
            step();
        end
        chk("t5_end_tvalid", 64'(m_tvalid), 64'(1'b0));

        // Reset after the second beat of a 32-byte message
        offer(16'd32, 1'b0);
        expect_beat("t6_b0", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
        step();
        expect_beat("t6_b1", 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 1'b0);
        step();
        chk("t6_b2_tvalid", 64'(m_tvalid), 64'(1'b1));
        rst = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid),  64'(1'b0));
        chk("t6_rst_ready",  64'(msg_ready), 64'(1'b0));
        chk("t6_rst_tlast",  64'(m_tlast),   64'(1'b0));
        chk("t6_rst_tdata",  m_tdata,        64'h0);
        step();
        rst = 1'b1;
        step();
        chk("t6_ready_after", 64'(msg_ready), 64'(1'b1));
        offer(16'd8, 1'b0);
        expect_beat("t6_new_b0", 64'h0807060504030201, 8'hFF, 1'b1, 1'b0);
        step();
        chk("t6_end_tvalid", 64'(m_tvalid), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
